// File: rtl/mul4_seq_pkg.sv
// Shared types and constants for the limb-serial multiplier sequencer.
package mul4_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int LIMB_W = 4;
   localparam int PP_W   = 8;

   // Index width: one count per limb pair, never narrower than one bit.
   function automatic int idx_w(input int opw);
      int npp;
      npp = (opw / LIMB_W) * (opw / LIMB_W);
      return (npp <= 1) ? 1 : $clog2(npp);
   endfunction

endpackage

// File: rtl/mul4_core.sv
// Combinational 4x4 unsigned multiplier core (stands in for the generated tree).
module mul4_core (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] o
);

   assign o = 8'(x) * 8'(y);

endmodule

// File: rtl/mul4_seq_ctrl.sv
// OPW x OPW unsigned multiply built by walking all 4-bit limb pairs through one
// shared 4x4 core. Optional MUL4_SEQ_ZERO_BYPASS_EN skips RUN for zero operands.
module mul4_seq_ctrl
   import mul4_seq_pkg::*;
#(
   parameter int OPW = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   in_a,
   input  logic [OPW-1:0]   in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*OPW-1:0] out_p,
   output logic             busy
);

   localparam int L   = OPW / LIMB_W;
   localparam int NPP = L * L;
   localparam int IW  = idx_w(OPW);
   localparam int PW  = 2 * OPW;

   localparam logic [IW-1:0] LAST = IW'(NPP - 1);
   localparam logic [IW-1:0] L_IW = IW'(L);

   state_t            state_q, state_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [OPW-1:0]    a_q, a_d, b_q, b_d;

   logic [IW-1:0]     li, lj;
   logic [IW+2:0]     shamt;
   logic [LIMB_W-1:0] limb_a, limb_b;
   logic [PP_W-1:0]   pp;

   // j (in_b limb) is the inner loop of the limb-pair walk.
   assign li     = idx_q / L_IW;
   assign lj     = idx_q % L_IW;
   assign limb_a = a_q[{li, 2'b00} +: LIMB_W];
   assign limb_b = b_q[{lj, 2'b00} +: LIMB_W];
   assign shamt  = {1'b0, li, 2'b00} + {1'b0, lj, 2'b00};

   mul4_core u_core (
      .x (limb_a),
      .y (limb_b),
      .o (pp)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d   = in_a;
               b_d   = in_b;
               acc_d = '0;
               idx_d = '0;
`ifdef MUL4_SEQ_ZERO_BYPASS_EN
               state_d = (in_a == '0 || in_b == '0) ? DONE : RUN;
`else
               state_d = RUN;
`endif
            end
         end
         RUN: begin
            acc_d = acc_q + (PW'(pp) << shamt);
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_p     = acc_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Directed bench for mul4_seq_ctrl at OPW=8 and OPW=12, plus random OPW=12 pairs.
module tb_mul4_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 0, busy8;
   logic [7:0]  in_a8 = 0, in_b8 = 0;
   logic [15:0] out_p8;

   logic        in_valid12 = 0, in_ready12, out_valid12, out_ready12 = 0, busy12;
   logic [11:0] in_a12 = 0, in_b12 = 0;
   logic [23:0] out_p12;

   int checks = 0;
   int failures = 0;

`ifdef MUL4_SEQ_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   mul4_seq_ctrl #(.OPW(8)) u_d8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_p(out_p8), .busy(busy8)
   );

   mul4_seq_ctrl #(.OPW(12)) u_d12 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid12), .in_ready(in_ready12), .in_a(in_a12), .in_b(in_b12),
      .out_valid(out_valid12), .out_ready(out_ready12), .out_p(out_p12), .busy(busy12)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // lat = edges from the accept edge until out_valid is seen high.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                      input int exp_lat, input int hold, input bit spam, input string tag);
      int lat;
      bit bad;
      chk({tag, "_in_ready"}, in_ready8, 1);
      in_a8 = a; in_b8 = b; in_valid8 = 1; out_ready8 = (hold == 0);
      @(posedge clk); #1;
      if (spam) begin
         in_a8 = 8'h11; in_b8 = 8'h22;
      end else begin
         in_valid8 = 0; in_a8 = ~a; in_b8 = ~b;
      end
      lat = 0; bad = 0;
      while (!out_valid8 && lat < 50) begin
         if (in_ready8 || !busy8) bad = 1;
         @(posedge clk); #1;
         lat++;
      end
      in_valid8 = 0;
      if (in_ready8 || !busy8) bad = 1;
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_p"}, out_p8, exp);
      chk({tag, "_busy"}, bad, 0);
      if (hold > 0) begin
         bad = 0;
         repeat (hold) begin
            @(posedge clk); #1;
            if (!out_valid8 || out_p8 !== exp) bad = 1;
         end
         chk({tag, "_hold"}, bad, 0);
      end
      out_ready8 = 1;
      @(posedge clk); #1;
      out_ready8 = 0;
      chk({tag, "_vld_drop"}, out_valid8, 0);
      chk({tag, "_idle"}, in_ready8, 1);
      chk({tag, "_p_keep"}, out_p8, exp);
   endtask

   task automatic op12(input logic [11:0] a, input logic [11:0] b, input logic [23:0] exp,
                       input int exp_lat, input string tag);
      int lat;
      in_a12 = a; in_b12 = b; in_valid12 = 1; out_ready12 = 1;
      @(posedge clk); #1;
      in_valid12 = 0;
      lat = 0;
      while (!out_valid12 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_p"}, out_p12, exp);
      @(posedge clk); #1;
      out_ready12 = 0;
   endtask

   initial begin
      logic [11:0] ra, rb;
      #12;
      chk("rst_in_ready", in_ready8, 1);
      chk("rst_out_valid", out_valid8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_out_p", out_p8, 0);
      chk("rst_out_p12", out_p12, 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      op8(8'hFF, 8'hFF, 16'hFE01, 4, 0, 0, "ff_ff");
      op8(8'h5A, 8'h3C, 16'h1518, 4, 10, 0, "hold");
      op8(8'h5A, 8'h3C, 16'h1518, 4, 0, 1, "spam");

      // Abort mid-RUN at idx=2.
      in_a8 = 8'h5A; in_b8 = 8'h3C; in_valid8 = 1;
      @(posedge clk); #1;
      in_valid8 = 0;
      repeat (2) begin @(posedge clk); #1; end
      chk("mid_busy", busy8, 1);
      rst_n = 0; #1;
      chk("abort_out_valid", out_valid8, 0);
      chk("abort_in_ready", in_ready8, 1);
      chk("abort_out_p", out_p8, 0);
      chk("abort_busy", busy8, 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      op8(8'h03, 8'h07, 16'h0015, 4, 0, 0, "after_rst");

      op8(8'h00, 8'hA7, 16'h0000, BYP ? 0 : 4, 0, 0, "zero_a");
      op8(8'h00, 8'hA7, 16'h0000, BYP ? 0 : 4, 2, 0, "zero_a_hold");

      op12(12'hABC, 12'hDEF, 24'h959184, 9, "w12_abc");
      op12(12'hFFF, 12'hFFF, 24'hFFE001, 9, "w12_max");
      for (int k = 0; k < 1000; k++) begin
         ra = 12'($urandom);
         rb = 12'($urandom);
         if (k == 500) ra = 12'h000;
         op12(ra, rb, 24'(ra) * 24'(rb), (BYP && (ra == 0 || rb == 0)) ? 0 : 9, "w12_rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
